// File: rtl/alu_seq.sv
// Multi-cycle 6502 arithmetic/logic sequencer driving a shared combinational 8-bit ALU.
// Adds a second ALU pass for the BCD adjust of ADC/SBC when the decimal flag is set.
module alu_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_cmd,
    input  logic [7:0] req_a,
    input  logic [7:0] req_m,
    input  logic       req_c,
    input  logic       req_d,
    output logic [7:0] alu_ai,
    output logic [7:0] alu_bi,
    output logic       alu_ci,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_out,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_c,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_wr,
    output logic       res_n,
    output logic       res_v,
    output logic       res_z,
    output logic       res_c,
    output logic [3:0] res_mask
);
    localparam logic [2:0] ALU_AND = 3'd0, ALU_OR = 3'd1, ALU_XOR = 3'd2, ALU_ADD = 3'd3,
                           ALU_SL  = 3'd4, ALU_SR = 3'd5, ALU_BIT = 3'd6;

    localparam logic [3:0] CMD_ADC = 4'd0, CMD_SBC = 4'd1, CMD_AND = 4'd2, CMD_ORA = 4'd3,
                           CMD_EOR = 4'd4, CMD_CMP = 4'd5, CMD_BIT = 4'd6, CMD_ASL = 4'd7,
                           CMD_LSR = 4'd8, CMD_ROL = 4'd9, CMD_ROR = 4'd10, CMD_INC = 4'd11,
                           CMD_DEC = 4'd12;

    typedef enum logic [1:0] {StIdle, StExec, StDadj, StDone} state_t;

    state_t     r_state, w_state_next;
    logic [3:0] r_cmd;
    logic [7:0] r_a, r_m;
    logic       r_c, r_d;
    logic [7:0] r_sum;
    logic       r_cb, r_hc, r_n, r_v, r_z;
    logic [7:0] r_res_data;
    logic       r_res_n, r_res_v, r_res_z, r_res_c, r_res_wr;
    logic [3:0] r_res_mask;

    logic       w_dec, w_lo, w_hi, w_wr;
    logic [3:0] w_mask;
    logic [7:0] w_corr, w_hsum, w_xdata;

    assign w_dec  = (r_cmd == CMD_ADC || r_cmd == CMD_SBC) && r_d;
    assign w_hsum = alu_ai ^ alu_bi ^ alu_out;

    // BCD correction from the binary pass; SBC subtracts 6 per digit that borrowed.
    assign w_lo = r_hc | (r_sum[3:0] > 4'd9);
    assign w_hi = r_cb | (r_sum > 8'h99);
    always_comb begin
        w_corr = 8'h00;
        if (r_cmd == CMD_ADC) begin
            w_corr = {(w_hi ? 4'h6 : 4'h0), (w_lo ? 4'h6 : 4'h0)};
        end else begin
            w_corr = (r_hc ? 8'h00 : 8'hFA) + (r_cb ? 8'h00 : 8'hA0);
        end
    end

    always_comb begin
        w_mask = 4'b0000;
        w_wr   = 1'b0;
        unique case (r_cmd)
            CMD_ADC, CMD_SBC:                            begin w_mask = 4'b1111; w_wr = 1'b1; end
            CMD_AND, CMD_ORA, CMD_EOR, CMD_INC, CMD_DEC: begin w_mask = 4'b1010; w_wr = 1'b1; end
            CMD_ASL, CMD_LSR, CMD_ROL, CMD_ROR:          begin w_mask = 4'b1011; w_wr = 1'b1; end
            CMD_CMP:                                     w_mask = 4'b1011;
            CMD_BIT:                                     w_mask = 4'b1110;
            default:                                     w_mask = 4'b0000;
        endcase
    end

    assign w_xdata = (r_cmd > CMD_DEC) ? r_a : alu_out;

    always_comb begin
        w_state_next = r_state;
        alu_ai       = 8'h00;
        alu_bi       = 8'h00;
        alu_ci       = 1'b0;
        alu_op       = ALU_AND;
        unique case (r_state)
            StIdle: if (req_valid) w_state_next = StExec;
            StExec: begin
                w_state_next = w_dec ? StDadj : StDone;
                alu_ai       = r_a;
                case (r_cmd)
                    CMD_ADC: begin alu_op = ALU_ADD; alu_bi = r_m;  alu_ci = r_c;  end
                    CMD_SBC: begin alu_op = ALU_ADD; alu_bi = ~r_m; alu_ci = r_c;  end
                    CMD_CMP: begin alu_op = ALU_ADD; alu_bi = ~r_m; alu_ci = 1'b1; end
                    CMD_AND: begin alu_op = ALU_AND; alu_bi = r_m; end
                    CMD_ORA: begin alu_op = ALU_OR;  alu_bi = r_m; end
                    CMD_EOR: begin alu_op = ALU_XOR; alu_bi = r_m; end
                    CMD_BIT: begin alu_op = ALU_BIT; alu_bi = r_m; end
                    CMD_ASL: alu_op = ALU_SL;
                    CMD_ROL: begin alu_op = ALU_SL; alu_ci = r_c; end
                    CMD_LSR: alu_op = ALU_SR;
                    CMD_ROR: begin alu_op = ALU_SR; alu_ci = r_c; end
                    CMD_INC: begin alu_op = ALU_ADD; alu_bi = 8'h01; end
                    CMD_DEC: begin alu_op = ALU_ADD; alu_bi = 8'hFF; end
                    default: alu_ai = 8'h00;
                endcase
            end
            StDadj: begin
                w_state_next = StDone;
                alu_op       = ALU_ADD;
                alu_ai       = r_sum;
                alu_bi       = w_corr;
            end
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cmd      <= 4'd0;
            r_a        <= 8'h00;
            r_m        <= 8'h00;
            r_c        <= 1'b0;
            r_d        <= 1'b0;
            r_sum      <= 8'h00;
            r_cb       <= 1'b0;
            r_hc       <= 1'b0;
            r_n        <= 1'b0;
            r_v        <= 1'b0;
            r_z        <= 1'b0;
            r_res_data <= 8'h00;
            r_res_n    <= 1'b0;
            r_res_v    <= 1'b0;
            r_res_z    <= 1'b0;
            r_res_c    <= 1'b0;
            r_res_wr   <= 1'b0;
            r_res_mask <= 4'b0000;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: if (req_valid) begin
                    r_cmd <= req_cmd;
                    r_a   <= req_a;
                    r_m   <= req_m;
                    r_c   <= req_c;
                    r_d   <= req_d;
                end
                StExec: begin
                    r_sum <= alu_out;
                    r_cb  <= alu_c;
                    r_hc  <= w_hsum[4];
                    r_n   <= alu_n;
                    r_v   <= alu_v;
                    r_z   <= alu_z;
                    // Result registers only change on entry to DONE so they hold between results.
                    if (!w_dec) begin
                        r_res_data <= w_xdata;
                        r_res_n    <= alu_n & w_mask[3];
                        r_res_v    <= alu_v & w_mask[2];
                        r_res_z    <= alu_z & w_mask[1];
                        r_res_c    <= alu_c & w_mask[0];
                        r_res_mask <= w_mask;
                        r_res_wr   <= w_wr;
                    end
                end
                StDadj: begin
                    r_res_data <= alu_out;
                    r_res_n    <= r_n;
                    r_res_v    <= r_v;
                    r_res_z    <= r_z;
                    r_res_c    <= (r_cmd == CMD_ADC) ? (r_cb | w_hi) : r_cb;
                    r_res_mask <= 4'b1111;
                    r_res_wr   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == StIdle);
    assign res_valid = (r_state == StDone);
    assign res_data  = r_res_data;
    assign res_n     = r_res_n;
    assign res_v     = r_res_v;
    assign res_z     = r_res_z;
    assign res_c     = r_res_c;
    assign res_wr    = r_res_wr;
    assign res_mask  = r_res_mask;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq: a behavioural ALU closes the loop and an
// arithmetic reference model (binary and true BCD) predicts every result.
module tb_alu_seq;
    localparam logic [2:0] ALU_AND = 3'd0, ALU_OR = 3'd1, ALU_XOR = 3'd2, ALU_ADD = 3'd3,
                           ALU_SL  = 3'd4, ALU_SR = 3'd5, ALU_BIT = 3'd6;

    logic       clk = 1'b0;
    logic       rst, req_valid, req_ready, req_c, req_d;
    logic [3:0] req_cmd;
    logic [7:0] req_a, req_m;
    logic [7:0] alu_ai, alu_bi, alu_out;
    logic       alu_ci, alu_n, alu_v, alu_z, alu_c;
    logic [2:0] alu_op;
    logic       res_valid, res_wr, res_n, res_v, res_z, res_c;
    logic [7:0] res_data;
    logic [3:0] res_mask;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_a(req_a), .req_m(req_m), .req_c(req_c), .req_d(req_d),
        .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_ci(alu_ci), .alu_op(alu_op),
        .alu_out(alu_out), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z), .alu_c(alu_c),
        .res_valid(res_valid), .res_data(res_data), .res_wr(res_wr),
        .res_n(res_n), .res_v(res_v), .res_z(res_z), .res_c(res_c), .res_mask(res_mask)
    );

    // Behavioural stand-in for the shared ALU.
    logic [8:0] alu_t;
    always_comb begin
        alu_t   = 9'd0;
        alu_out = 8'h00;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                alu_t   = {1'b0, alu_ai} + {1'b0, alu_bi} + {8'd0, alu_ci};
                alu_out = alu_t[7:0];
                alu_c   = alu_t[8];
                alu_v   = (alu_ai[7] == alu_bi[7]) && (alu_out[7] != alu_ai[7]);
            end
            ALU_AND: alu_out = alu_ai & alu_bi;
            ALU_OR:  alu_out = alu_ai | alu_bi;
            ALU_XOR: alu_out = alu_ai ^ alu_bi;
            ALU_BIT: begin alu_out = alu_ai & alu_bi; alu_v = alu_bi[6]; end
            ALU_SL:  begin alu_out = {alu_ai[6:0], alu_ci}; alu_c = alu_ai[7]; end
            ALU_SR:  begin alu_out = {alu_ci, alu_ai[7:1]}; alu_c = alu_ai[0]; end
            default: alu_out = 8'h00;
        endcase
        alu_n = (alu_op == ALU_BIT) ? alu_bi[7] : alu_out[7];
        alu_z = (alu_out == 8'h00);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [7:0] x);
        return x[7] ? int'(x) - 256 : int'(x);
    endfunction

    function automatic int bcd(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic void ref_model(input logic [3:0] cmd, input logic [7:0] a, m,
                                      input logic c, d, output logic [7:0] data,
                                      output logic [3:0] fl, output logic [3:0] mask,
                                      output logic wr, output int lat, output bit chk_data);
        int s, sv, r;
        logic n, v, z, cf;
        n = 0; v = 0; z = 0; cf = 0; data = a; mask = 4'b0000; wr = 0; lat = 2; chk_data = 1;
        case (cmd)
            4'd0, 4'd1: begin
                if (cmd == 4'd0) begin
                    s  = int'(a) + int'(m) + int'(c);
                    sv = sx(a) + sx(m) + int'(c);
                end else begin
                    s  = int'(a) - int'(m) - 1 + int'(c) + 256;
                    sv = sx(a) - sx(m) - 1 + int'(c);
                end
                data = s[7:0];
                cf = s > 255;
                v  = (sv > 127) || (sv < -128);
                n  = data[7];
                z  = (data == 8'h00);
                mask = 4'b1111; wr = 1;
                if (d) begin
                    lat = 3;
                    if (cmd == 4'd0) begin
                        r = bcd(a) + bcd(m) + int'(c);
                        cf = r > 99;
                        r = r % 100;
                    end else begin
                        r = bcd(a) - bcd(m) - 1 + int'(c);
                        cf = r >= 0;
                        if (r < 0) r += 100;
                    end
                    data = {4'(r / 10), 4'(r % 10)};
                end
            end
            4'd2: begin data = a & m; mask = 4'b1010; wr = 1; end
            4'd3: begin data = a | m; mask = 4'b1010; wr = 1; end
            4'd4: begin data = a ^ m; mask = 4'b1010; wr = 1; end
            4'd5: begin
                s = int'(a) - int'(m);
                n = s[7]; z = (a == m); cf = (a >= m);
                mask = 4'b1011; chk_data = 0;
            end
            4'd6: begin
                n = m[7]; v = m[6]; z = ((a & m) == 8'h00);
                mask = 4'b1110; chk_data = 0;
            end
            4'd7:  begin data = a << 1;           cf = a[7]; mask = 4'b1011; wr = 1; end
            4'd8:  begin data = a >> 1;           cf = a[0]; mask = 4'b1011; wr = 1; end
            4'd9:  begin data = {a[6:0], c};      cf = a[7]; mask = 4'b1011; wr = 1; end
            4'd10: begin data = {c, a[7:1]};      cf = a[0]; mask = 4'b1011; wr = 1; end
            4'd11: begin data = a + 8'd1;         mask = 4'b1010; wr = 1; end
            4'd12: begin data = a - 8'd1;         mask = 4'b1010; wr = 1; end
            default: data = a;
        endcase
        if (cmd >= 4'd2 && cmd != 4'd5 && cmd != 4'd6 && cmd <= 4'd12) begin
            n = data[7];
            z = (data == 8'h00);
        end
        fl = {n, v, z, cf} & mask;
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("ready_idle", 32'(req_ready), 32'd1);
    endtask

    task automatic run_cmd(input logic [3:0] cmd, input logic [7:0] a, m, input logic c, d);
        logic [7:0] e_data;
        logic [3:0] e_fl, e_mask;
        logic       e_wr;
        int         e_lat, cyc;
        bit         chk_data;
        ref_model(cmd, a, m, c, d, e_data, e_fl, e_mask, e_wr, e_lat, chk_data);
        wait_ready();
        req_cmd = cmd; req_a = a; req_m = m; req_c = c; req_d = d; req_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble the request lines; they must be ignored while busy.
        req_valid = 1'b0;
        req_cmd = 4'($urandom); req_a = 8'($urandom); req_m = 8'($urandom);
        req_c = 1'($urandom); req_d = 1'($urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check_eq("busy_ready", 32'(req_ready), 32'd0);
        end while (!res_valid && cyc < 10);
        check_eq("latency", 32'(cyc), 32'(e_lat));
        if (chk_data) check_eq("data", 32'(res_data), 32'(e_data));
        check_eq("flags_nvzc", 32'({res_n, res_v, res_z, res_c}), 32'(e_fl));
        check_eq("mask", 32'(res_mask), 32'(e_mask));
        check_eq("wr", 32'(res_wr), 32'(e_wr));
        @(negedge clk);
        check_eq("valid_pulse", 32'(res_valid), 32'd0);
        if (chk_data) check_eq("data_hold", 32'(res_data), 32'(e_data));
    endtask

    function automatic logic [7:0] rand_bcd();
        return {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
    endfunction

    initial begin
        logic [3:0] cmd;
        logic [7:0] a, m;
        logic       d;
        int         cyc;

        // Reset with a request pending: it must be dropped.
        rst = 1'b1; req_valid = 1'b1; req_cmd = 4'd0; req_a = 8'h55; req_m = 8'h33;
        req_c = 1'b1; req_d = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_ready", 32'(req_ready), 32'd1);
            check_eq("rst_valid", 32'(res_valid), 32'd0);
            check_eq("rst_alu", 32'({alu_ai, alu_bi, alu_ci, alu_op}), 32'd0);
            check_eq("rst_res", 32'({res_data, res_mask, res_wr, res_n, res_v, res_z, res_c}),
                     32'd0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_valid", 32'(res_valid), 32'd0);

        // Directed cases.
        run_cmd(4'd0,  8'h50, 8'h50, 1'b0, 1'b0);
        run_cmd(4'd0,  8'h99, 8'h01, 1'b0, 1'b1);
        run_cmd(4'd0,  8'h99, 8'h01, 1'b0, 1'b0);
        run_cmd(4'd1,  8'h00, 8'h01, 1'b1, 1'b1);
        run_cmd(4'd1,  8'h46, 8'h12, 1'b1, 1'b1);
        run_cmd(4'd5,  8'h10, 8'h20, 1'b0, 1'b0);
        run_cmd(4'd6,  8'h0F, 8'hC0, 1'b0, 1'b0);
        run_cmd(4'd10, 8'h01, 8'h00, 1'b1, 1'b0);
        run_cmd(4'd11, 8'hFF, 8'h00, 1'b0, 1'b0);
        run_cmd(4'd12, 8'h00, 8'h00, 1'b0, 1'b0);
        run_cmd(4'd14, 8'h5A, 8'hA5, 1'b1, 1'b1);

        // Reset while in the decimal-adjust pass abandons the command.
        wait_ready();
        req_cmd = 4'd0; req_a = 8'h58; req_m = 8'h46; req_c = 1'b1; req_d = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        repeat (2) begin
            @(negedge clk);
            cyc++;
            check_eq("abort_no_valid", 32'(res_valid), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_valid", 32'(res_valid), 32'd0);
        check_eq("abort_ready", 32'(req_ready), 32'd1);
        check_eq("abort_res", 32'(res_data), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check_eq("abort_quiet", 32'(res_valid), 32'd0);
        end

        // Randomized commands; decimal ADC/SBC use valid BCD operands.
        for (int i = 0; i < 300; i++) begin
            cmd = 4'($urandom);
            d   = 1'($urandom);
            a   = 8'($urandom);
            m   = 8'($urandom);
            if (cmd <= 4'd1 && d) begin
                a = rand_bcd();
                m = rand_bcd();
            end
            run_cmd(cmd, a, m, 1'($urandom), d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle sequencer that turns 6502 instruction-level arithmetic/logic commands into passes over the shared 8-bit `alu` datapath. It accepts one command at a time from the control unit and drives the ALU operand, carry and op inputs. It performs the second decimal-adjust pass for ADC/SBC when D=1, and returns the result byte with NVZC values and a flag-write mask for the register file / P register.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: command request.
- `req_ready` out 1: high only in IDLE.
- `req_cmd` in 4: 0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 CMP, 6 BIT, 7 ASL, 8 LSR, 9 ROL, 10 ROR, 11 INC, 12 DEC, 13-15 NOP.
- `req_a` in 8: register operand, or target of shift/INC/DEC.
- `req_m` in 8: memory operand.
- `req_c` in 1: current carry flag.
- `req_d` in 1: current decimal flag.
- `alu_ai`, `alu_bi` out 8: ALU operands.
- `alu_ci` out 1: ALU carry in.
- `alu_op` out 3: ALU op, using the package `ALU_*` enumeration.
- `alu_out` in 8, `alu_n`/`alu_v`/`alu_z`/`alu_c` in 1: ALU results.
- `res_valid` out 1: one-cycle result strobe.
- `res_data` out 8: result byte.
- `res_wr` out 1: destination register/memory is written.
- `res_n`, `res_v`, `res_z`, `res_c` out 1: flag values.
- `res_mask` out 4: {N,V,Z,C} flag write enables.

## Operation
- States: IDLE, EXEC, DADJ, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch cmd, a, m, c and d, then go to EXEC.
- EXEC:
  - Drive the ALU from the latched values and register `alu_out`/flags.
  - Go to DADJ if cmd is ADC/SBC with d=1; otherwise go to DONE.
- DADJ:
  - Drive ALU_ADD with ai = binary sum, bi = correction, ci = 0.
  - Register `alu_out` as `res_data`, then go to DONE.
- DONE:
  - `res_valid`=1 for exactly one cycle, then return to IDLE.
  - No backpressure on the result.
- ALU drive in EXEC:
  - ADC: ADD, a, m, c.
  - SBC: ADD, a, ~m, c.
  - CMP: ADD, a, ~m, 1.
  - AND/ORA/EOR: AND/OR/XOR, a, m.
  - BIT: ALU_BIT, a, m.
  - ASL: SL, a, 0, ci 0. ROL: SL, a, 0, c.
  - LSR: SR, a, 0, ci 0. ROR: SR, a, 0, c.
  - INC: ADD, a, 0x01, 0. DEC: ADD, a, 0xFF, 0.
  - The unused shift port must be 0.
- Decimal correction (sum s and carry cb from EXEC; half-carry hc = (ai^bi^s)[4]):
  - ADC: lo = hc | (s[3:0]>9); hi = cb | (s>0x99).
  - ADC correction = {hi?6:0, lo?6:0}.
  - ADC final C = cb | hi.
  - SBC: correction = (!hc ? 0xFA : 0) + (!cb ? 0xA0 : 0), mod 256; final C = cb.
  - In decimal mode N, V and Z come from the binary EXEC result. Only `res_data` and C are corrected.
- Masks and writes:
  - ADC/SBC: NVZC, wr=1.
  - AND/ORA/EOR/INC/DEC: NZ, wr=1.
  - ASL/LSR/ROL/ROR: NZC, wr=1.
  - CMP: NZC, wr=0.
  - BIT: NVZ, wr=0 (N=m[7], V=m[6], Z from a&m).
  - NOP: mask 0, wr=0, res_data=a.
- Flags not in the mask are driven 0.

## Timing
- Reset values:
  - State IDLE, `req_ready`=1, `res_valid`=0.
  - `res_*`, `res_mask` and `alu_*` all 0; `alu_op` = ALU_AND encoding with zero operands.
- Latency, with accept at cycle T:
  - Binary: `res_valid` at T+2.
  - Decimal ADC/SBC: `res_valid` at T+3.
- Throughput: one command per 3 cycles (binary) or 4 cycles (decimal); `req_ready`=0 from T+1 until return to IDLE.
- `res_*` hold their values after DONE until the next DONE.
- `req_*` are ignored outside IDLE.
- `req_valid` together with `rst`: reset wins and the command is dropped.
- Reset in EXEC/DADJ/DONE: the operation is abandoned with no `res_valid`, and `req_ready`=1 in the following cycle.
- ALU outputs are sampled combinationally in the same cycle that the inputs are driven (the ALU is purely combinational).
- Wrap-around is modulo 256: INC 0xFF gives 0x00 with Z=1; DEC 0x00 gives 0xFF with N=1.

## Test plan
- Reset: hold `rst` for 2 cycles with `req_valid`=1 → `req_ready`=1, `res_valid` never asserts, all `alu_*` = 0.
- Binary ADC, a=0x50, m=0x50, c=0, d=0 → at T+2: data 0xA0, N=1, V=1, Z=0, C=0, mask 1111, wr=1.
- Decimal ADC, a=0x99, m=0x01, c=0, d=1 → at T+3: data 0x00, C=1, N=1, Z=0, V=0 (binary 0x9A). Same ADC with d=0 gives 0x9A at T+2.
- Decimal SBC, a=0x00, m=0x01, c=1, d=1 → data 0x99, C=0.
  - SBC a=0x46, m=0x12, c=1 → data 0x34, C=1.
- CMP a=0x10, m=0x20 → wr=0, mask 1011, N=1, Z=0, C=0.
  - BIT a=0x0F, m=0xC0 → N=1, V=1, Z=1, mask 1110.
- ROR a=0x01, c=1 → data 0x80, C=1, N=1.
  - INC 0xFF → data 0x00, Z=1.
  - Decimal ADC with `rst` asserted in DADJ → no `res_valid`, `req_ready`=1 next cycle.
